mem_load_ctrl: RTL and testbench
================================

Name: mem_load_ctrl

Overview:
- Boot-time loader and arbiter between an external loader port, the riscv_cpu core, and the instruction/data memories.
- Holds the CPU in reset and accepts a valid/ready stream of words, which it writes into the instruction or data memory.
- Releases the CPU after a programmable delay, then passes the CPU's data-memory port through unchanged.
- Replaces the combinational reset-time write mux with a handshaked, counted, range-checked load sequence.

Parameters:
- XLEN, 32: data and address width in bits.
- IMEM_WORDS, 64: instruction memory depth in words; bounds range check for region 0.
- DMEM_WORDS, 64: data memory depth in words; bounds range check for region 1.
- AUTO_INC, 1: 1 = word pointer auto-increments per accepted beat; 0 = every beat uses ext_addr.
- RELEASE_CYCLES, 4: cycles cpu_reset stays high after load completes (legal range 1..255).
- CNT_W, 16: width of the loaded-word counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ext_start  in  1  begin/restart a load session; ext_addr is the start word address
- ext_valid  in  1  loader beat valid
- ext_ready  out  1  block can accept a beat
- ext_region  in  1  0 = instruction memory, 1 = data memory
- ext_addr  in  XLEN  word address (start address, or per-beat address when AUTO_INC=0)
- ext_data  in  XLEN  word to write
- ext_done  in  1  end of load session
- cpu_reset  out  1  active-high reset to riscv_cpu
- cpu_memwrite  in  1  CPU data write enable
- cpu_adr  in  XLEN  CPU data byte address
- cpu_wdata  in  XLEN  CPU write data
- cpu_funct3  in  3  CPU store size (Instr[14:12])
- imem_we  out  1  instruction memory write enable
- imem_adr  out  XLEN  instruction memory byte address
- imem_wdata  out  XLEN  instruction memory write data
- dmem_we  out  1  data memory write enable
- dmem_adr  out  XLEN  data memory byte address
- dmem_wdata  out  XLEN  data memory write data
- dmem_funct3  out  3  data memory store size
- word_cnt  out  CNT_W  words written in the current session; saturating
- load_err  out  1  sticky flag: an out-of-range beat occurred
- busy  out  1  high in LOAD and DRAIN

Behaviour:
- Reset (reset=0, async):
  - state=HOLD, cpu_reset=1, ext_ready=0.
  - imem_we=dmem_we=0, all address/data outputs 0, dmem_funct3=3'b010.
  - word_cnt=0, load_err=0, busy=0, pointer=0.
- HOLD: cpu_reset=1.
  - ext_start -> LOAD next cycle; pointer<=ext_addr; word_cnt<=0; load_err<=0.
- LOAD: ext_ready=1, busy=1.
  - Beat = ext_valid && ext_ready.
  - Write outputs are registered: the write appears 1 cycle after the beat.
  - Write fields: region-selected we=1, adr={pointer,2'b00}, wdata=ext_data, dmem_funct3=3'b010.
  - Beat address = pointer if AUTO_INC=1, else ext_addr.
  - AUTO_INC=1: pointer increments by 1 per beat and wraps modulo 2^(XLEN-2).
- Range check: beat address >= IMEM_WORDS (region 0) or >= DMEM_WORDS (region 1):
  - beat is still accepted;
  - no write is issued;
  - load_err<=1;
  - word_cnt is not incremented.
- word_cnt increments on each in-range beat and saturates at 2^CNT_W-1.
- ext_done in LOAD -> DRAIN. A beat in the same cycle is accepted first.
- DRAIN: 1 cycle, ext_ready=0; the last registered write retires. Then load the release counter with RELEASE_CYCLES and go to REL.
- REL: cpu_reset=1, ext_ready=0, counter decrements each cycle.
  - When the counter reaches 0: go to RUN and deassert cpu_reset on the same edge.
- RUN: cpu_reset=0, imem_we=0, ext_ready=0.
  - dmem_we/adr/wdata/funct3 = cpu_* inputs, combinational pass-through (zero latency).
- ext_start in RUN or REL -> LOAD next cycle. cpu_reset is registered high on that edge, and the pointer and counters reinitialise as in HOLD.
- ext_start while in LOAD: pointer reloads; word_cnt and load_err are not cleared; a simultaneous beat uses the old pointer.
- ext_valid outside LOAD is ignored.
- Reset mid-load: any pending registered write is dropped (we=0) immediately.

Decomposition:
- Package mem_load_pkg:
  - state encoding HOLD/LOAD/DRAIN/REL/RUN (3 bits);
  - FUNCT3_SW=3'b010;
  - REGION_IMEM=1'b0, REGION_DMEM=1'b1.
- Sub-module rst_release_timer: 8-bit down-counter (load, tick, zero flag), async active-low reset.

Test Plan:
- Reset released, ext_start with ext_addr=0, 4 beats to region 1 with data 0x11..0x44, then ext_done -> dmem_we pulses at byte addresses 0,4,8,12 one cycle after each beat; word_cnt=4; cpu_reset falls exactly RELEASE_CYCLES+2 cycles after ext_done.
- AUTO_INC=0, beats to region 0 at ext_addr=3 then 1 -> imem_adr=12 then 4; dmem_we stays 0.
- Region 1 beat at ext_addr=DMEM_WORDS (64) -> ext_ready high, no write, load_err=1, word_cnt unchanged; load_err persists into RUN.
- In RUN, cpu_memwrite=1, cpu_adr=0x20, cpu_wdata=0xDEAD, cpu_funct3=3'b000 -> same-cycle dmem outputs match exactly; imem_we=0.
- Beat coincident with ext_done -> beat written; DRAIN seen; a beat with CNT_W=2 after 3 prior beats -> word_cnt saturates at 3.
- reset asserted one cycle after a beat -> no write pulse, all outputs at reset values, cpu_reset=1; ext_start in RUN -> cpu_reset=1 next cycle and word_cnt=0.

Source files
------------

// File: rtl/mem_load_pkg.sv
// Shared types and constants for the boot-time memory loader.
package mem_load_pkg;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_REL   = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

    localparam logic [2:0]  FUNCT3_SW   = 3'b010;
    localparam logic        REGION_IMEM = 1'b0;
    localparam logic        REGION_DMEM = 1'b1;
    localparam int unsigned TMR_W       = 8;

endpackage

// File: rtl/rst_release_timer.sv
// Down-counter that times how long the CPU stays in reset after a load.
module rst_release_timer
    import mem_load_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TMR_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_load_ctrl.sv
// Boot loader: holds the CPU in reset, writes a handshaked word stream into
// instruction/data memory, then releases the CPU and passes its data port through.
module mem_load_ctrl
    import mem_load_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned IMEM_WORDS     = 64,
    parameter int unsigned DMEM_WORDS     = 64,
    parameter int unsigned AUTO_INC       = 1,
    parameter int unsigned RELEASE_CYCLES = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ext_start_i,
    input  logic             ext_valid_i,
    output logic             ext_ready_o,
    input  logic             ext_region_i,
    input  logic [XLEN-1:0]  ext_addr_i,
    input  logic [XLEN-1:0]  ext_data_i,
    input  logic             ext_done_i,
    output logic             cpu_reset_o,
    input  logic             cpu_memwrite_i,
    input  logic [XLEN-1:0]  cpu_adr_i,
    input  logic [XLEN-1:0]  cpu_wdata_i,
    input  logic [2:0]       cpu_funct3_i,
    output logic             imem_we_o,
    output logic [XLEN-1:0]  imem_adr_o,
    output logic [XLEN-1:0]  imem_wdata_o,
    output logic             dmem_we_o,
    output logic [XLEN-1:0]  dmem_adr_o,
    output logic [XLEN-1:0]  dmem_wdata_o,
    output logic [2:0]       dmem_funct3_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic             load_err_o,
    output logic             busy_o
);

    localparam int unsigned      PTR_W   = XLEN - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              imem_we_q, imem_we_d;
    logic              dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]   wr_adr_q, wr_adr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              beat;
    logic [XLEN-1:0]   beat_addr;
    logic              in_range;
    logic              tmr_load, tmr_tick, tmr_zero;
    logic              run;

    assign beat      = ready_q && ext_valid_i;
    assign beat_addr = (AUTO_INC != 0) ? XLEN'(ptr_q) : ext_addr_i;
    assign in_range  = (ext_region_i == REGION_DMEM) ? (beat_addr < XLEN'(DMEM_WORDS))
                                                     : (beat_addr < XLEN'(IMEM_WORDS));

    rst_release_timer u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(RELEASE_CYCLES)),
        .tick_i     (tmr_tick),
        .zero_o     (tmr_zero)
    );

    // Next-state and next-register logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        imem_we_d = 1'b0;
        dmem_we_d = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
        tmr_load  = 1'b0;
        tmr_tick  = 1'b0;

        case (state_q)
            ST_HOLD, ST_RUN: begin
                if (ext_start_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = PTR_W'(ext_addr_i);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (in_range) begin
                        imem_we_d = (ext_region_i == REGION_IMEM);
                        dmem_we_d = (ext_region_i == REGION_DMEM);
                        wr_adr_d  = {beat_addr[PTR_W-1:0], 2'b00};
                        wr_data_d = ext_data_i;
                        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if (AUTO_INC != 0) begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
                // A restart reloads the pointer after the beat has used the old one
                if (ext_start_i) begin
                    ptr_d = PTR_W'(ext_addr_i);
                end else if (ext_done_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d  = ST_REL;
                tmr_load = 1'b1;
            end
            ST_REL: begin
                if (ext_start_i) begin
                    state_d = ST_LOAD;
                    ptr_d   = PTR_W'(ext_addr_i);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (tmr_zero) begin
                    state_d = ST_RUN;
                end else begin
                    tmr_tick = 1'b1;
                end
            end
            default: state_d = ST_HOLD;
        endcase

        cpu_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_LOAD);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_HOLD;
            ptr_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            wr_adr_q    <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            wr_adr_q    <= wr_adr_d;
            wr_data_q   <= wr_data_d;
            cpu_reset_q <= cpu_reset_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // Once the CPU runs, its data port reaches memory with zero latency
    assign run           = (state_q == ST_RUN);
    assign dmem_we_o     = run ? cpu_memwrite_i : dmem_we_q;
    assign dmem_adr_o    = run ? cpu_adr_i      : wr_adr_q;
    assign dmem_wdata_o  = run ? cpu_wdata_i    : wr_data_q;
    assign dmem_funct3_o = run ? cpu_funct3_i   : FUNCT3_SW;

    assign imem_we_o     = imem_we_q;
    assign imem_adr_o    = wr_adr_q;
    assign imem_wdata_o  = wr_data_q;
    assign ext_ready_o   = ready_q;
    assign cpu_reset_o   = cpu_reset_q;
    assign busy_o        = busy_q;
    assign word_cnt_o    = cnt_q;
    assign load_err_o    = err_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Bench for mem_load_ctrl: two parameterisations share one stimulus stream and
// are checked every cycle against a session-level model plus literal expectations.
module tb_mem_load_ctrl;

    localparam int P_HOLD = 0, P_LOAD = 1, P_DRAIN = 2, P_REL = 3, P_RUN = 4;

    typedef struct {
        int          phase;
        logic [29:0] ptr;
        int          cnt;
        bit          err;
        int          rel;
        bit          iwe;
        bit          dwe;
        logic [31:0] adr;
        logic [31:0] wdata;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_start = 1'b0, ext_valid = 1'b0, ext_region = 1'b0, ext_done = 1'b0;
    logic [31:0] ext_addr = '0, ext_data = '0;
    logic        cpu_memwrite = 1'b0;
    logic [31:0] cpu_adr = '0, cpu_wdata = '0;
    logic [2:0]  cpu_funct3 = '0;

    logic        a_ready, a_cpu_reset, a_iwe, a_dwe, a_err, a_busy;
    logic [31:0] a_iadr, a_iwd, a_dadr, a_dwd;
    logic [2:0]  a_f3;
    logic [15:0] a_cnt;
    logic        b_ready, b_cpu_reset, b_iwe, b_dwe, b_err, b_busy;
    logic [31:0] b_iadr, b_iwd, b_dadr, b_dwd;
    logic [2:0]  b_f3;
    logic [1:0]  b_cnt;

    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    mem_load_ctrl u_a (
        .clk_i(clk), .rst_ni(rst_n), .ext_start_i(ext_start), .ext_valid_i(ext_valid),
        .ext_ready_o(a_ready), .ext_region_i(ext_region), .ext_addr_i(ext_addr),
        .ext_data_i(ext_data), .ext_done_i(ext_done), .cpu_reset_o(a_cpu_reset),
        .cpu_memwrite_i(cpu_memwrite), .cpu_adr_i(cpu_adr), .cpu_wdata_i(cpu_wdata),
        .cpu_funct3_i(cpu_funct3), .imem_we_o(a_iwe), .imem_adr_o(a_iadr),
        .imem_wdata_o(a_iwd), .dmem_we_o(a_dwe), .dmem_adr_o(a_dadr), .dmem_wdata_o(a_dwd),
        .dmem_funct3_o(a_f3), .word_cnt_o(a_cnt), .load_err_o(a_err), .busy_o(a_busy)
    );

    mem_load_ctrl #(.AUTO_INC(0), .RELEASE_CYCLES(2), .CNT_W(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .ext_start_i(ext_start), .ext_valid_i(ext_valid),
        .ext_ready_o(b_ready), .ext_region_i(ext_region), .ext_addr_i(ext_addr),
        .ext_data_i(ext_data), .ext_done_i(ext_done), .cpu_reset_o(b_cpu_reset),
        .cpu_memwrite_i(cpu_memwrite), .cpu_adr_i(cpu_adr), .cpu_wdata_i(cpu_wdata),
        .cpu_funct3_i(cpu_funct3), .imem_we_o(b_iwe), .imem_adr_o(b_iadr),
        .imem_wdata_o(b_iwd), .dmem_we_o(b_dwe), .dmem_adr_o(b_dadr), .dmem_wdata_o(b_dwd),
        .dmem_funct3_o(b_f3), .word_cnt_o(b_cnt), .load_err_o(b_err), .busy_o(b_busy)
    );

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = P_HOLD; m.ptr = '0; m.cnt = 0; m.err = 1'b0; m.rel = 0;
        m.iwe = 1'b0; m.dwe = 1'b0; m.adr = '0; m.wdata = '0;
        return m;
    endfunction

    // One clock of the loader session as described by its rules
    function automatic mdl_t mdl_step(mdl_t m, bit auto_inc, int cmax, int relc);
        logic [31:0] baddr;
        int          limit;
        m.iwe = 1'b0;
        m.dwe = 1'b0;
        if (m.phase == P_LOAD) begin
            if (ext_valid) begin
                baddr = auto_inc ? {2'b00, m.ptr} : ext_addr;
                limit = ext_region ? 64 : 64;
                if (baddr < 32'(limit)) begin
                    m.iwe   = !ext_region;
                    m.dwe   = ext_region;
                    m.adr   = baddr * 4;
                    m.wdata = ext_data;
                    if (m.cnt < cmax) m.cnt = m.cnt + 1;
                end else begin
                    m.err = 1'b1;
                end
                if (auto_inc) m.ptr = m.ptr + 30'd1;
            end
            if (ext_start) m.ptr = ext_addr[29:0];
            else if (ext_done) m.phase = P_DRAIN;
        end else if (ext_start && m.phase != P_DRAIN) begin
            m.phase = P_LOAD; m.ptr = ext_addr[29:0]; m.cnt = 0; m.err = 1'b0;
        end else if (m.phase == P_DRAIN) begin
            m.phase = P_REL; m.rel = relc;
        end else if (m.phase == P_REL) begin
            if (m.rel == 0) m.phase = P_RUN;
            else m.rel = m.rel - 1;
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_step(ma, 1'b1, 65535, 4);
            mb = mdl_step(mb, 1'b0, 3, 2);
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input mdl_t m,
                              input logic cr, input logic rdy, input logic bsy,
                              input logic iwe, input logic [31:0] iadr, input logic [31:0] iwd,
                              input logic dwe, input logic [31:0] dadr, input logic [31:0] dwd,
                              input logic [2:0] f3, input logic [31:0] cnt, input logic err);
        cmp({tag, ".cpu_reset"}, 32'(cr), 32'(m.phase != P_RUN));
        cmp({tag, ".ready"}, 32'(rdy), 32'(m.phase == P_LOAD));
        cmp({tag, ".busy"}, 32'(bsy), 32'(m.phase == P_LOAD || m.phase == P_DRAIN));
        cmp({tag, ".word_cnt"}, cnt, 32'(m.cnt));
        cmp({tag, ".load_err"}, 32'(err), 32'(m.err));
        cmp({tag, ".imem_we"}, 32'(iwe), 32'(m.iwe));
        if (m.iwe) begin
            cmp({tag, ".imem_adr"}, iadr, m.adr);
            cmp({tag, ".imem_wdata"}, iwd, m.wdata);
        end
        if (m.phase == P_RUN) begin
            cmp({tag, ".run_dmem_we"}, 32'(dwe), 32'(cpu_memwrite));
            cmp({tag, ".run_dmem_adr"}, dadr, cpu_adr);
            cmp({tag, ".run_dmem_wdata"}, dwd, cpu_wdata);
            cmp({tag, ".run_dmem_funct3"}, 32'(f3), 32'(cpu_funct3));
        end else begin
            cmp({tag, ".dmem_we"}, 32'(dwe), 32'(m.dwe));
            cmp({tag, ".dmem_funct3"}, 32'(f3), 32'(3'b010));
            if (m.dwe) begin
                cmp({tag, ".dmem_adr"}, dadr, m.adr);
                cmp({tag, ".dmem_wdata"}, dwd, m.wdata);
            end
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check_inst("A", ma, a_cpu_reset, a_ready, a_busy, a_iwe, a_iadr, a_iwd,
                       a_dwe, a_dadr, a_dwd, a_f3, 32'(a_cnt), a_err);
            check_inst("B", mb, b_cpu_reset, b_ready, b_busy, b_iwe, b_iadr, b_iwd,
                       b_dwe, b_dadr, b_dwd, b_f3, 32'(b_cnt), b_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_release(output int na, output int nb);
        int n = 0;
        na = -1;
        nb = -1;
        while ((a_cpu_reset || b_cpu_reset) && n < 50) begin
            tick();
            n++;
            if (!a_cpu_reset && na < 0) na = n;
            if (!b_cpu_reset && nb < 0) nb = n;
        end
    endtask

    initial begin
        int na, nb;

        tick();
        chk_en = 1'b1;
        cmp("rst.cpu_reset", 32'(a_cpu_reset), 32'd1);
        cmp("rst.ready", 32'(a_ready), 32'd0);
        cmp("rst.funct3", 32'(a_f3), 32'h2);
        cmp("rst.imem_adr", a_iadr, 32'd0);
        tick();
        rst_n = 1'b1;

        // Beats outside LOAD are ignored
        ext_valid = 1'b1; ext_region = 1'b1;
        tick();
        tick();
        cmp("hold.dmem_we", 32'(a_dwe), 32'd0);
        ext_valid = 1'b0;

        // Four data beats, last one coincident with ext_done
        ext_start = 1'b1; ext_addr = 32'd0;
        tick();
        ext_start = 1'b0;
        cmp("load.ready", 32'(a_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ext_valid = 1'b1; ext_region = 1'b1;
            ext_addr = 32'(i); ext_data = 32'(8'h11 * (i + 1)); ext_done = (i == 3);
            tick();
            cmp("seq.dmem_we", 32'(a_dwe), 32'd1);
            cmp("seq.dmem_adr", a_dadr, 32'(4 * i));
            cmp("seq.dmem_wdata", a_dwd, 32'(8'h11 * (i + 1)));
        end
        ext_valid = 1'b0; ext_done = 1'b0;
        cmp("drain.busy", 32'(a_busy), 32'd1);
        cmp("drain.ready", 32'(a_ready), 32'd0);
        cmp("seq.word_cnt", 32'(a_cnt), 32'd4);
        cmp("sat.word_cnt", 32'(b_cnt), 32'd3);
        wait_release(na, nb);
        cmp("release_delay_A", 32'(na), 32'd6);
        cmp("release_delay_B", 32'(nb), 32'd4);

        // Pass-through in RUN
        cpu_memwrite = 1'b1; cpu_adr = 32'h20; cpu_wdata = 32'hDEAD; cpu_funct3 = 3'b000;
        #1;
        cmp("run.dmem_we", 32'(a_dwe), 32'd1);
        cmp("run.dmem_adr", a_dadr, 32'h20);
        cmp("run.dmem_wdata", a_dwd, 32'hDEAD);
        cmp("run.funct3", 32'(a_f3), 32'd0);
        cmp("run.imem_we", 32'(a_iwe), 32'd0);
        tick();
        cpu_memwrite = 1'b0;

        // Restart from RUN, instruction beats at 3 then 1
        ext_start = 1'b1; ext_addr = 32'd3; ext_region = 1'b0;
        tick();
        ext_start = 1'b0;
        cmp("restart.cpu_reset", 32'(a_cpu_reset), 32'd1);
        cmp("restart.word_cnt", 32'(a_cnt), 32'd0);
        ext_valid = 1'b1; ext_addr = 32'd3; ext_data = 32'hA0;
        tick();
        cmp("imem1.adr_B", b_iadr, 32'd12);
        cmp("imem1.adr_A", a_iadr, 32'd12);
        cmp("imem1.dmem_we_B", 32'(b_dwe), 32'd0);
        ext_addr = 32'd1; ext_data = 32'hA1;
        tick();
        cmp("imem2.adr_B", b_iadr, 32'd4);
        cmp("imem2.adr_A", a_iadr, 32'd16);
        ext_valid = 1'b0;

        // Pointer reload in LOAD then out-of-range data beat
        ext_start = 1'b1; ext_addr = 32'd64;
        tick();
        ext_start = 1'b0;
        ext_valid = 1'b1; ext_region = 1'b1; ext_data = 32'hBB;
        tick();
        ext_valid = 1'b0;
        cmp("oor.ready", 32'(a_ready), 32'd1);
        cmp("oor.dmem_we", 32'(a_dwe), 32'd0);
        cmp("oor.load_err", 32'(a_err), 32'd1);
        cmp("oor.word_cnt", 32'(a_cnt), 32'd2);
        cmp("oor.load_err_B", 32'(b_err), 32'd1);
        ext_done = 1'b1;
        tick();
        ext_done = 1'b0;
        wait_release(na, nb);
        cmp("oor.release_A", 32'(na), 32'd6);
        cmp("run.load_err", 32'(a_err), 32'd1);

        // Reset right after an accepted beat
        ext_start = 1'b1; ext_addr = 32'd5;
        tick();
        ext_start = 1'b0;
        ext_valid = 1'b1; ext_region = 1'b1; ext_data = 32'h55;
        tick();
        rst_n = 1'b0;
        ext_valid = 1'b0;
        #1;
        cmp("midrst.dmem_we", 32'(a_dwe), 32'd0);
        cmp("midrst.dmem_adr", a_dadr, 32'd0);
        cmp("midrst.cpu_reset", 32'(a_cpu_reset), 32'd1);
        cmp("midrst.word_cnt", 32'(a_cnt), 32'd0);
        cmp("midrst.ready", 32'(a_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
